// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a loadable note table as divider/gate pairs for the tone generator
module melody_sequencer #(
  parameter int NOTES = 16,
  parameter int TICK_DIV = 1000000,
  parameter int GAP_CYC = 4,
  parameter int DIV_W = 15,
  localparam int IW = $clog2(NOTES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_addr,
  input  logic [DIV_W+3:0] wr_data,
  output logic [DIV_W-1:0] divider,
  output logic             gate,
  output logic             busy,
  output logic [IW-1:0]    note_idx,
  output logic             done
);
  localparam int TW = $clog2(TICK_DIV > 1 ? TICK_DIV : 2);
  localparam int GW = $clog2(GAP_CYC > 1 ? GAP_CYC : 2);
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
  state_t state;
  logic [DIV_W+3:0] tbl [NOTES];
  logic [DIV_W+3:0] ent;
  logic [TW-1:0] tick;
  logic [3:0] rem;
  logic [GW-1:0] gap;
  logic tick_last, step;
  assign ent = tbl[note_idx];
  assign tick_last = tick == TW'(TICK_DIV - 1);
  // step fires on the last cycle of a note, after its gap if there is one
  assign step = (state == PLAY && tick_last && rem == 4'd0 && GAP_CYC == 0) ||
                (state == GAP && gap == GW'(GAP_CYC - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NOTES; i++) tbl[i] <= '0;
    else if (wr_en)
      tbl[wr_addr] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      note_idx <= '0;
      tick <= '0;
      rem <= '0;
      gap <= '0;
      divider <= '0;
      gate <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop && state != IDLE) begin
        state <= IDLE;
        divider <= '0;
        gate <= 1'b0;
        busy <= 1'b0;
      end else if (step) begin
        divider <= '0;
        gate <= 1'b0;
        if (note_idx != IW'(NOTES - 1) || loop) begin
          state <= LOAD;
          note_idx <= note_idx + 1'b1;
        end else begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else
        case (state)
          IDLE: if (start && !stop) begin
            state <= LOAD;
            note_idx <= '0;
            busy <= 1'b1;
          end
          LOAD: begin
            state <= PLAY;
            tick <= '0;
            rem <= ent[3:0];
            divider <= ent[DIV_W+3:4];
            gate <= |ent[DIV_W+3:4];
          end
          PLAY: begin
            tick <= tick_last ? '0 : tick + 1'b1;
            if (tick_last && rem != 4'd0) rem <= rem - 1'b1;
            if (tick_last && rem == 4'd0) begin
              state <= GAP;
              gap <= '0;
              divider <= '0;
              gate <= 1'b0;
            end
          end
          GAP: gap <= gap + 1'b1;
        endcase
    end
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: vector table for the reference song plus a per-note timing model for the rest
module tb_melody_sequencer;
  localparam int NOTES = 4, TICK_DIV = 4, GAP_CYC = 2, DIV_W = 15, IW = 2;
  logic clk = 0, rst_n = 0, start = 0, stop = 0, loop = 0, wr_en = 0;
  logic [IW-1:0] wr_addr = '0;
  logic [DIV_W+3:0] wr_data = '0;
  logic [DIV_W-1:0] divider;
  logic gate, busy, done;
  logic [IW-1:0] note_idx;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  melody_sequencer #(.NOTES(NOTES), .TICK_DIV(TICK_DIV), .GAP_CYC(GAP_CYC), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .divider(divider), .gate(gate), .busy(busy), .note_idx(note_idx), .done(done)
  );
  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic gate;
    logic busy;
    logic [IW-1:0] idx;
    logic done;
  } obs_t;
  typedef struct {
    bit start;
    bit stop;
    bit loop;
    int n;
    obs_t e;
  } vec_t;
  obs_t exp_q[$];
  int pass_start[$];
  logic [DIV_W-1:0] m_div [NOTES];
  logic [3:0] m_d [NOTES];
  vec_t vt [15];
  function automatic obs_t mk(input int dv, input int ix, input bit b, input bit dn);
    obs_t o;
    o.div = DIV_W'(dv);
    o.gate = (dv != 0);
    o.busy = b;
    o.idx = IW'(ix);
    o.done = dn;
    return o;
  endfunction
  task automatic check(input string nm, input obs_t e);
    obs_t a;
    a = {divider, gate, busy, note_idx, done};
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got div=%h gate=%b busy=%b idx=%0d done=%b, want div=%h gate=%b busy=%b idx=%0d done=%b",
               nm, a.div, a.gate, a.busy, a.idx, a.done, e.div, e.gate, e.busy, e.idx, e.done);
    end
  endtask
  task automatic wr(input int a, input int dv, input int d);
    wr_en = 1;
    wr_addr = IW'(a);
    wr_data = {DIV_W'(dv), 4'(d)};
    m_div[a] = DIV_W'(dv);
    m_d[a] = 4'(d);
    @(posedge clk); #1;
    wr_en = 0;
  endtask
  // one pass of the song: each note is LOAD, (d+1) ticks sounding, then the gap
  task automatic add_pass();
    pass_start.push_back(exp_q.size());
    for (int i = 0; i < NOTES; i++) begin
      exp_q.push_back(mk(0, i, 1, 0));
      repeat ((int'(m_d[i]) + 1) * TICK_DIV) exp_q.push_back(mk(int'(m_div[i]), i, 1, 0));
      repeat (GAP_CYC) exp_q.push_back(mk(0, i, 1, 0));
    end
  endtask
  task automatic add_tail();
    exp_q.push_back(mk(0, NOTES - 1, 0, 1));
    repeat (2) exp_q.push_back(mk(0, NOTES - 1, 0, 0));
  endtask
  // start is pulsed before edge 0; other events are applied before the edge of their index
  task automatic run_trace(input string nm, input int start_at, input int stop_at, input int drop_at,
                           input int wr_at, input logic [IW-1:0] wa, input logic [DIV_W+3:0] wd);
    for (int i = 0; i < exp_q.size(); i++) begin
      start = (i == 0 || i == start_at);
      stop = (i == stop_at);
      if (i == drop_at) loop = 0;
      wr_en = (i == wr_at);
      wr_addr = wa;
      wr_data = wd;
      @(posedge clk); #1;
      start = 0;
      stop = 0;
      wr_en = 0;
      check($sformatf("%s[%0d]", nm, i), exp_q[i]);
    end
    exp_q.delete();
    pass_start.delete();
  endtask
  initial begin
    for (int i = 0; i < NOTES; i++) begin
      m_div[i] = '0;
      m_d[i] = '0;
    end
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1,  mk(0, 0, 1, 0)};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 8,  mk('h1000, 0, 1, 0)};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 2,  mk(0, 0, 1, 0)};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 1,  mk(0, 1, 1, 0)};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 4,  mk('h0800, 1, 1, 0)};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 2,  mk(0, 1, 1, 0)};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1,  mk(0, 2, 1, 0)};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 4,  mk(0, 2, 1, 0)};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 2,  mk(0, 2, 1, 0)};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 1,  mk(0, 3, 1, 0)};
    vt[10] = '{1'b0, 1'b0, 1'b0, 12, mk('h2000, 3, 1, 0)};
    vt[11] = '{1'b0, 1'b0, 1'b0, 2,  mk(0, 3, 1, 0)};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1,  mk(0, 3, 0, 1)};
    vt[13] = '{1'b0, 1'b0, 1'b0, 2,  mk(0, 3, 0, 0)};
    vt[14] = '{1'b1, 1'b1, 1'b0, 3,  mk(0, 3, 0, 0)};
    repeat (2) @(posedge clk);
    #1 check("reset", mk(0, 0, 0, 0));
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    check("idle", mk(0, 0, 0, 0));
    wr(0, 'h1000, 1);
    wr(1, 'h0800, 0);
    wr(2, 0, 0);
    wr(3, 'h2000, 2);
    foreach (vt[j]) begin
      start = vt[j].start;
      stop = vt[j].stop;
      loop = vt[j].loop;
      for (int k = 0; k < vt[j].n; k++) begin
        @(posedge clk); #1;
        start = 0;
        stop = 0;
        check($sformatf("vec%0d.%0d", j, k), vt[j].e);
      end
    end
    loop = 1;
    add_pass(); add_pass(); add_tail();
    run_trace("loop", -1, -1, pass_start[1] + 1, -1, '0, '0);
    add_pass(); add_tail();
    exp_q = exp_q[0:14];
    repeat (3) exp_q.push_back(mk(0, 1, 0, 0));
    run_trace("stop", -1, 15, -1, -1, '0, '0);
    add_pass(); add_tail();
    run_trace("restart", -1, -1, -1, -1, '0, '0);
    add_pass(); add_tail();
    run_trace("midstart", 20, -1, -1, -1, '0, '0);
    loop = 1;
    add_pass();
    m_div[1] = 'h0100;
    m_d[1] = 0;
    add_pass(); add_tail();
    run_trace("wrplay", -1, -1, pass_start[1] + 1, 13, 2'd1, {15'h0100, 4'd0});
    for (int r = 0; r < 6; r++) begin
      int passes;
      for (int i = 0; i < NOTES; i++)
        wr(i, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 'h7fff)), int'($urandom_range(0, 3)));
      passes = int'($urandom_range(1, 2));
      loop = (passes > 1);
      repeat (passes) add_pass();
      add_tail();
      run_trace($sformatf("rnd%0d", r), int'($urandom_range(1, exp_q.size() - 3)), -1,
                passes > 1 ? pass_start[1] + 1 : -1, -1, '0, '0);
    end
    start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk);
    #3 rst_n = 0;
    #1 check("async_rst", mk(0, 0, 0, 0));
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < NOTES; i++) begin
      m_div[i] = '0;
      m_d[i] = '0;
    end
    @(posedge clk); #1;
    check("post_rst", mk(0, 0, 0, 0));
    add_pass(); add_tail();
    run_trace("zero_tbl", -1, -1, -1, -1, '0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
